// File: rtl/bcd_operand_pkg.sv
// Shared types and helpers for the keypad BCD operand collector.
// Arithmetic helpers are fixed at 32 bits; callers truncate to their width.
package bcd_operand_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int ACC_MAX_W = 32;

    function automatic logic [31:0] mul10_add(
        input logic [31:0] acc,
        input logic [3:0]  digit
    );
        return (acc << 3) + (acc << 1) + {28'd0, digit};
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge event from a synchronous level strobe.
// A level already high out of reset must fall once before it can fire.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic rise_o
);

    logic lvl_q;
    logic armed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            lvl_q   <= lvl_i;
            armed_q <= armed_q | ~lvl_i;
        end
    end

    assign rise_o = lvl_i & ~lvl_q & armed_q;

endmodule

// File: rtl/bcd_operand_collector.sv
// Collects signed BCD operands from a keypad and presents them
// as two's complement words under a valid/ready handshake.
module bcd_operand_collector
    import bcd_operand_pkg::*;
#(
    parameter  int DIGITS   = 2,
    parameter  int OPERANDS = 2,
    parameter  int OUT_W    = 8,
    localparam int OPW = (OPERANDS > 1) ? $clog2(OPERANDS) : 1,
    localparam int DGW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dat_ready,
    input  logic [3:0]                dato,
    input  logic                      signo,
    input  logic                      clear,
    input  logic                      ready,
    output logic [OPERANDS*OUT_W-1:0] operands_o,
    output logic                      valid,
    output logic                      err,
    output logic [OPW-1:0]            op_idx,
    output logic [DGW-1:0]            digit_idx
);

    if (OUT_W > ACC_MAX_W ||
        (longint'(1) << (OUT_W - 1)) <= pow10(DIGITS) - 1) begin : g_bad_width
        $error("OUT_W too small for DIGITS");
    end

    logic rise;

    rise_detect u_rise (
        .clk    (clk),
        .rst    (rst),
        .lvl_i  (dat_ready),
        .rise_o (rise)
    );

    state_e                    state_q;
    logic [OUT_W-1:0]          acc_q;
    logic [OUT_W-1:0]          acc_d;
    logic [OUT_W-1:0]          val_d;
    logic                      sign_q;
    logic                      sign_d;
    logic [OPW-1:0]            op_idx_q;
    logic [DGW-1:0]            digit_idx_q;
    logic [OPERANDS*OUT_W-1:0] slots_q;
    logic                      valid_q;
    logic                      err_q;
    logic                      last_dig;
    logic                      last_op;

    always_comb begin
        acc_d    = OUT_W'(mul10_add(32'(acc_q), dato));
        sign_d   = (digit_idx_q == '0) ? signo : sign_q;
        val_d    = sign_d ? -acc_d : acc_d;
        last_dig = (digit_idx_q == DGW'(DIGITS - 1));
        last_op  = (op_idx_q == OPW'(OPERANDS - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COLLECT;
            acc_q       <= '0;
            sign_q      <= 1'b0;
            op_idx_q    <= '0;
            digit_idx_q <= '0;
            slots_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (clear) begin
                state_q     <= COLLECT;
                acc_q       <= '0;
                sign_q      <= 1'b0;
                op_idx_q    <= '0;
                digit_idx_q <= '0;
                slots_q     <= '0;
                valid_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    COLLECT: if (rise) begin
                        if (dato > BCD_MAX) begin
                            err_q <= 1'b1;
                        end else if (!last_dig) begin
                            acc_q       <= acc_d;
                            sign_q      <= sign_d;
                            digit_idx_q <= digit_idx_q + DGW'(1);
                        end else begin
                            for (int k = 0; k < OPERANDS; k++)
                                if (op_idx_q == OPW'(k))
                                    slots_q[k*OUT_W +: OUT_W] <= val_d;
                            acc_q       <= '0;
                            sign_q      <= 1'b0;
                            digit_idx_q <= '0;
                            if (last_op) begin
                                op_idx_q <= '0;
                                valid_q  <= 1'b1;
                                state_q  <= HOLD;
                            end else begin
                                op_idx_q <= op_idx_q + OPW'(1);
                            end
                        end
                    end
                    HOLD: if (ready) begin
                        valid_q <= 1'b0;
                        state_q <= COLLECT;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign operands_o = slots_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign op_idx     = op_idx_q;
    assign digit_idx  = digit_idx_q;

endmodule

// File: doc/bcd_operand_collector.md
Name: bcd_operand_collector

Overview:
- Parametrised successor to the two-operand keypad entry FSM that feeds the multiplier datapath.
- Collects OPERANDS signed decimal operands, each entered as DIGITS BCD digits (most significant digit first) plus a sign.
- Converts each operand to two's complement OUT_W bits and presents all operands together under a valid/ready handshake.
- Adds behaviour the earlier block lacked: rejection of illegal digits, abort/clear, backpressure, and progress indices for the display.

Parameters:
DIGITS, 2, BCD digits per operand (>=1)
OPERANDS, 2, number of operands collected per transaction (>=1)
OUT_W, 8, output width per operand; elaboration assertion requires 2^(OUT_W-1) > 10^DIGITS-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
dat_ready  in  1  keypad strobe, level, already synchronous to clk; one digit per rising edge
dato  in  4  BCD digit, sampled on the dat_ready rising-edge cycle
signo  in  1  sign of current operand (1 = negative)
clear  in  1  synchronous abort of the current entry
ready  in  1  consumer accepts operands
operands_o  out  OPERANDS*OUT_W  packed operands; slot k at bits [k*OUT_W +: OUT_W]
valid  out  1  all operands complete and stable
err  out  1  one-cycle pulse on a rejected digit
op_idx  out  max(1,$clog2(OPERANDS))  operand currently being entered
digit_idx  out  max(1,$clog2(DIGITS))  next digit position within the operand

Behaviour:
- Reset: state COLLECT; all of the following are 0: valid, err, op_idx, digit_idx, accumulator, captured sign, every operands_o slot, and the delayed dat_ready register.
- Edge detect: rise = dat_ready & ~dat_ready_q, where dat_ready_q is registered.
  - A level held high yields exactly one event.
  - If dat_ready is already high when rst releases, no event occurs until it falls and rises again.
- States: COLLECT and HOLD.
- COLLECT, rise with dato <= 9 (accepted digit):
  - acc_next = (acc<<3) + (acc<<1) + dato, kept in OUT_W bits, unsigned.
  - When digit_idx == 0, signo is captured as the operand sign. signo is ignored on later digits.
  - Not last digit: acc <= acc_next; digit_idx increments.
  - Last digit (digit_idx == DIGITS-1):
    - slot[op_idx] <= sign ? -acc_next : acc_next; a negative zero stores 0.
    - acc, sign and digit_idx are cleared.
    - If op_idx == OPERANDS-1: op_idx <= 0, valid <= 1, state <= HOLD. Otherwise op_idx increments.
- COLLECT, rise with dato > 9: err is 1 for the next cycle only; no other state changes.
- Latency: valid is high in the cycle after the clock edge that samples the final digit's rise.
- HOLD:
  - valid = 1 and operands_o are stable.
  - All rise events are ignored: no err, no index change.
  - Transfer occurs at the edge where valid && ready. At that edge: valid <= 0, state <= COLLECT.
  - operands_o keep their values until overwritten by new entry.
- clear (synchronous, highest priority in any state):
  - Clears state to COLLECT, plus acc, sign, indices, valid, and every slot (to 0).
  - A digit event in the same cycle is discarded.
  - clear with valid && ready in the same cycle: the transfer counts; clear still applies.
- Reset mid-entry: immediate asynchronous return to reset values; partial operands are lost.
- ready while valid = 0 is a don't-care.

Decomposition:
- Package bcd_operand_pkg:
  - state enum typedef {COLLECT, HOLD}
  - constant BCD_MAX = 4'd9
  - function mul10_add(acc, digit)
- Sub-module rise_detect: the registered delay plus AND-NOT, with async active-low reset. It is reusable by other keypad-driven blocks.
- Everything else lives in bcd_operand_collector: FSM, accumulator, slot registers, handshake.

Test Plan:
- Defaults. Digits 4,2 with signo=0, then 1,3 with signo=1 on the first digit -> slot0 = 8'h2A, slot1 = 8'hF3, valid high one cycle after the final edge, held while ready = 0.
- Mid-operand dato = 4'hB -> err high exactly 1 cycle; digit_idx and acc unchanged. Then digit 7 is accepted normally.
- dat_ready held high for 20 cycles -> exactly one digit accepted, digit_idx advances by 1.
- In HOLD with ready = 0 for 10 cycles, pulse dat_ready 3 times -> no change and no err. Then ready = 1 -> valid low next cycle, op_idx = digit_idx = 0, operands_o unchanged.
- clear after 3 digits -> valid 0, all slots 0, indices 0. Fresh entry of 9,9 / 0,0 with signo=1 -> slot0 = 8'h63, slot1 = 8'h00.
- DIGITS=3, OPERANDS=3, OUT_W=11: enter -999, +123, +0 -> slots 11'h419, 11'h07B, 11'h000. Asserting rst during the second operand returns all outputs to 0 immediately.
